qam_coherent_demod: RTL
=======================

// Module: qam_coherent_demod
// PURPOSE
//  Coherent 16-QAM demodulator; downstream consumer of the modulator's 13-bit qam sample stream.
//  Mixes each sample with the local cos/sin carrier and integrates over one symbol period.
//  Slices each integral to a 2-bit level code and re-serialises the 4 bits per symbol.
//  Closes the loop-back path for self-checking the modulation chain.
// PARAMETERS
//  SPS      8       samples per symbol; must be >= 4, so serialiser always drains before next symbol
//  ACC_W    30      integrator width, signed; >= 23 + clog2(SPS)
//  THRESH   131072  outer-level decision threshold applied to |integral|
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  sym_sync   in   1   1-cycle strobe: next accepted sample is sample 0 of a symbol
//  in_valid   in   1   qam/cos_in/sin_in valid this cycle
//  qam        in   13  received sample, signed (I_mod - Q_mod)
//  cos_in     in   10  local carrier cosine, signed, phase-aligned to modulator
//  sin_in     in   10  local carrier sine, signed
//  sym_valid  out  1   1-cycle pulse: sym_i/sym_q updated
//  sym_i      out  2   I level code
//  sym_q      out  2   Q level code
//  bit_out    out  1   serial bit; order I[1], I[0], Q[1], Q[0]
//  bit_valid  out  1   bit_out valid
//  locked     out  1   high once first sym_sync seen since reset
// BEHAVIOUR
//  Reset: all outputs 0; integrators 0; sample counter 0; FSM=HUNT; serialiser IDLE.
//  FSM HUNT -> TRACK on sym_sync. In HUNT, samples are ignored and locked=0.
//  TRACK stays until rst; locked=1 in TRACK.
//  Mix stage, registered, 1 cycle:
//   p_i = qam*cos_in
//   p_q = -(qam*sin_in)
//   Both 23-bit signed, full precision, sign-extended to ACC_W.
//  Integrate: on each valid product, acc += p. Counter counts 0..SPS-1.
//  On the product with count SPS-1: slice acc+p, clear acc, wrap counter to 0.
//  Slicer, per axis, on integral v:
//   v >= THRESH         -> 2'b11 (+3)
//   0 <= v < THRESH     -> 2'b10 (+1)
//   -THRESH <= v < 0    -> 2'b01 (-1)
//   v < -THRESH         -> 2'b00 (-3)
//  Slice result is registered; sym_valid pulses 2 clk after the last sample's in_valid cycle.
//  sym_i/sym_q hold their value until the next symbol.
//  Serialiser: loads 4 bits when sym_valid is high, then shifts 1 bit/clk.
//   bit_valid is high for exactly 4 consecutive cycles, starting the cycle after sym_valid.
//  Gaps: in_valid low stalls the mix/integrate stages. No sample is lost or duplicated.
//  sym_sync in TRACK, mid-symbol: partial integral is discarded and the counter restarts.
//   No sym_valid is generated for the partial symbol.
//  sym_sync with in_valid in the same cycle: that sample is sample 0.
//  A product in flight from the prior symbol is discarded.
//  Overflow: none by construction; ACC_W is sized for the worst case (SPS * 2^22).
//  rst mid-symbol or mid-serialisation: everything is cleared next edge; bit_valid drops immediately.
// CONFIGURATION
//  QAM_DEMOD_ERR_EN defined:
//   Adds outputs err_i/err_q [ACC_W-1:0], unsigned.
//   Each is |v - nearest ideal level|, ideal levels = +-THRESH/2 and +-3*THRESH/2.
//   Updated with sym_valid; reset 0.
//  QAM_DEMOD_ERR_EN undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Package qam_demod_pkg:
//   level code constants LVL_N3 = 00, LVL_N1 = 01, LVL_P1 = 10, LVL_P3 = 11
//   QAM_W = 13, CARRIER_W = 10, PROD_W = 23
//   FSM state enum {HUNT, TRACK}
//  Sub-module qam_slicer (ACC_W, THRESH): combinational decision plus optional error term.
//   Instanced for I and for Q.
// TESTING (SPS=8, THRESH=131072)
//  1 Reset: after rst, all outputs 0, locked=0. Samples before sym_sync -> no sym_valid.
//  2 sym_sync; 8x {qam=100, cos=256, sin=0}:
//     acc_i = 204800 -> sym_i = 11; acc_q = 0 -> sym_q = 10.
//     bits 1,1,1,0 on 4 cycles after sym_valid.
//  3 8x {qam=-50, cos=256, sin=0} -> sym_i = 01. 8x {qam=-100, cos=0, sin=256} -> sym_q = 11.
//  4 Same stimulus as test 2 with in_valid low every other cycle -> identical codes.
//     sym_valid arrives 2 clk after the 8th valid sample.
//  5 sym_sync after 5 samples, then 8 samples of test 3 -> exactly one sym_valid, codes from test 3.
//  6 rst asserted during 2nd serial bit -> bit_valid = 0 next cycle, locked = 0, no further bits.
// QAM_DEMOD_ERR_EN: test 2 -> err_i = 8192, err_q = 65536.

Source files
------------

// File: rtl/qam_demod_pkg.sv
// Shared widths, level codes and state encoding for the coherent 16-QAM demodulator.
// Used by qam_coherent_demod and qam_slicer (optional error outputs: QAM_DEMOD_ERR_EN).
package qam_demod_pkg;

    localparam int QAM_W     = 13;
    localparam int CARRIER_W = 10;
    localparam int PROD_W    = 23;

    localparam logic [1:0] LVL_N3 = 2'b00;
    localparam logic [1:0] LVL_N1 = 2'b01;
    localparam logic [1:0] LVL_P1 = 2'b10;
    localparam logic [1:0] LVL_P3 = 2'b11;

    typedef enum logic {
        HUNT,
        TRACK
    } demod_state_t;

endpackage

// File: rtl/qam_coherent_demod_slicer.sv
// Combinational 4-level decision on one axis integral.
// With QAM_DEMOD_ERR_EN defined, also reports |v - nearest ideal level|.
module qam_slicer
    import qam_demod_pkg::*;
#(
    parameter int ACC_W  = 30,
    parameter int THRESH = 131072
) (
    input  logic signed [ACC_W-1:0] v,
    output logic        [1:0]       code
`ifdef QAM_DEMOD_ERR_EN
    ,
    output logic        [ACC_W-1:0] err
`endif
);

    localparam logic signed [ACC_W-1:0] T_POS = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0] T_NEG = -T_POS;

    always_comb begin
        if (v >= T_POS)
            code = LVL_P3;
        else if (!v[ACC_W-1])
            code = LVL_P1;
        else if (v >= T_NEG)
            code = LVL_N1;
        else
            code = LVL_N3;
    end

`ifdef QAM_DEMOD_ERR_EN
    localparam logic signed [ACC_W-1:0] L1 = ACC_W'(THRESH / 2);
    localparam logic signed [ACC_W-1:0] L3 = ACC_W'((3 * THRESH) / 2);

    logic signed [ACC_W-1:0] ideal;
    logic signed [ACC_W-1:0] diff;

    // The nearest ideal level is always the centre of the decided region.
    always_comb begin
        case (code)
            LVL_P3:  ideal = L3;
            LVL_P1:  ideal = L1;
            LVL_N1:  ideal = -L1;
            default: ideal = -L3;
        endcase
        diff = v - ideal;
        err  = diff[ACC_W-1] ? -diff : diff;
    end
`endif

endmodule

// File: rtl/qam_coherent_demod.sv
// Coherent 16-QAM demodulator: mix, integrate per symbol, slice, re-serialise.
// Optional per-axis decision error outputs when QAM_DEMOD_ERR_EN is defined.
module qam_coherent_demod
    import qam_demod_pkg::*;
#(
    parameter int SPS    = 8,
    parameter int ACC_W  = 30,
    parameter int THRESH = 131072
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sym_sync,
    input  logic                        in_valid,
    input  logic signed [QAM_W-1:0]     qam,
    input  logic signed [CARRIER_W-1:0] cos_in,
    input  logic signed [CARRIER_W-1:0] sin_in,
    output logic                        sym_valid,
    output logic        [1:0]           sym_i,
    output logic        [1:0]           sym_q,
    output logic                        bit_out,
    output logic                        bit_valid,
    output logic                        locked
`ifdef QAM_DEMOD_ERR_EN
    ,
    output logic        [ACC_W-1:0]     err_i,
    output logic        [ACC_W-1:0]     err_q
`endif
);

    localparam int CNT_W = $clog2(SPS);

    demod_state_t state, state_next;

    logic                     accept;
    logic [CNT_W-1:0]         cnt, cnt_eff;
    logic signed [PROD_W-1:0] p_i, p_q;
    logic                     p_valid, p_last;
    logic signed [ACC_W-1:0]  acc_i, acc_q, sum_i, sum_q;
    logic [1:0]               code_i, code_q;
    logic [1:0]               bits_left;
    logic [2:0]               shreg;
`ifdef QAM_DEMOD_ERR_EN
    logic [ACC_W-1:0]         err_i_w, err_q_w;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= HUNT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == HUNT && sym_sync)
            state_next = TRACK;
    end

    always_comb begin
        locked = (state == TRACK);
    end

    // A strobe in HUNT with in_valid already accepts that sample as sample 0.
    assign accept  = in_valid && (state == TRACK || sym_sync);
    assign cnt_eff = sym_sync ? '0 : cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p_i     <= '0;
            p_q     <= '0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_i    <= PROD_W'(qam) * PROD_W'(cos_in);
                p_q    <= -(PROD_W'(qam) * PROD_W'(sin_in));
                p_last <= (cnt_eff == CNT_W'(SPS - 1));
                cnt    <= (cnt_eff == CNT_W'(SPS - 1)) ? '0 : cnt_eff + 1'b1;
            end else if (sym_sync) begin
                cnt <= '0;
            end
        end
    end

    assign sum_i = acc_i + ACC_W'(p_i);
    assign sum_q = acc_q + ACC_W'(p_q);

    qam_slicer #(.ACC_W(ACC_W), .THRESH(THRESH)) u_slicer_i (
        .v    (sum_i),
        .code (code_i)
`ifdef QAM_DEMOD_ERR_EN
        ,
        .err  (err_i_w)
`endif
    );

    qam_slicer #(.ACC_W(ACC_W), .THRESH(THRESH)) u_slicer_q (
        .v    (sum_q),
        .code (code_q)
`ifdef QAM_DEMOD_ERR_EN
        ,
        .err  (err_q_w)
`endif
    );

    // sym_sync also drops the product still in the mix register from the old symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i     <= '0;
            acc_q     <= '0;
            sym_valid <= 1'b0;
            sym_i     <= '0;
            sym_q     <= '0;
`ifdef QAM_DEMOD_ERR_EN
            err_i     <= '0;
            err_q     <= '0;
`endif
        end else begin
            sym_valid <= 1'b0;
            if (sym_sync) begin
                acc_i <= '0;
                acc_q <= '0;
            end else if (p_valid) begin
                if (p_last) begin
                    acc_i     <= '0;
                    acc_q     <= '0;
                    sym_i     <= code_i;
                    sym_q     <= code_q;
                    sym_valid <= 1'b1;
`ifdef QAM_DEMOD_ERR_EN
                    err_i     <= err_i_w;
                    err_q     <= err_q_w;
`endif
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                end
            end
        end
    end

    // First bit goes straight out on load; the remaining three sit in shreg.
    always_ff @(posedge clk) begin
        if (rst) begin
            bits_left <= '0;
            shreg     <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else if (sym_valid) begin
            bit_out   <= sym_i[1];
            shreg     <= {sym_i[0], sym_q};
            bits_left <= 2'd3;
            bit_valid <= 1'b1;
        end else if (bits_left != '0) begin
            bit_out   <= shreg[2];
            shreg     <= {shreg[1:0], 1'b0};
            bits_left <= bits_left - 1'b1;
            bit_valid <= 1'b1;
        end else begin
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end
    end

endmodule
